dmem_ctrl: RTL
==============

# dmem_ctrl

Load/store controller that sequences the core's byte-laned data memory: four 8-bit synchronous-read DMem banks sharing one 6-bit word address. It accepts one load or store request at a time from the execute stage and converts byte, halfword and word accesses into lane write-enables and per-lane write data. On loads it extracts and sign- or zero-extends the read data, then returns a single-cycle response. It sits between the core datapath (ALU address, regfile data) and the DMem instances.

## Interface
- ADDR_W, 8, byte address width; word index is ADDR_W-2 bits.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller idle and able to accept.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_signed  in  1  sign-extend load result (ignored for word and stores).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  formatted load data; 0 when rsp_valid=0 or for stores.
- rsp_err  out  1  access rejected; valid with rsp_valid.
- mem_addr  out  ADDR_W-2  word address to all four banks.
- mem_we  out  4  per-lane write enable; lane i = bits [8i+7:8i], little-endian (lane 0 = byte addr mod 4 = 0).
- mem_wdata  out  32  per-lane write data.
- mem_rdata  in  32  concatenated bank outputs, valid the cycle after the address edge.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid at a clock edge, latch we/size/signed/addr/wdata and go to ACCESS. If the request is misaligned (MISALIGN_TRAP_EN), go to RESP with the error flag set; no memory access occurs.
- ACCESS: mem_addr = latched addr[ADDR_W-1:2]. For stores, mem_we carries the lane mask. Always go to RESP.
- RESP: rsp_valid=1 and rsp_err = latched error. Go to IDLE.
- Store lane mask: byte 0001<<addr[1:0]; half addr[1] ? 1100 : 0011; word 1111.
- Store wdata: byte replicated ×4; half replicated ×2; word as-is.
- Load: byte = mem_rdata[8·addr[1:0]+:8]; half = mem_rdata[16·addr[1]+:16]; extend to 32 bits by sign if req_signed, else by zero.
- Misaligned: half with addr[0]=1; word with addr[1:0]≠0; size 11 is always an error (rsp_err=1, no access, in both configurations).
- mem_we is 0 in every state except store ACCESS. mem_addr holds its last value outside ACCESS.
- req_valid while not IDLE is ignored; the requester holds it until accepted.

## Timing
- Load or store accepted at edge E0: ACCESS in cycle E0–E1, memory acts at E1, rsp_valid in cycle E1–E2, and req_ready high again after E2. Latency is 2 cycles; throughput is 1 request per 3 cycles.
- Error accepted at E0: rsp_valid in cycle E0–E1; req_ready after E1.
- rsp_rdata is combinational from mem_rdata during RESP.
- Reset (any time, including mid-ACCESS): state→IDLE immediately. mem_we=0, rsp_valid=0, rsp_err=0, rsp_rdata=0 and mem_addr=0 asynchronously. req_ready=0 while rst=1 and 1 after release. An in-flight store write is aborted: no write occurs if rst is asserted before E1.

## Configuration
- DMEM_CTRL_MISALIGN_TRAP_EN defined: misaligned half/word requests produce rsp_err=1 with no memory access.
- Undefined: low address bits below the access size are ignored. A half uses addr[1], a word uses lanes 1111, and the access proceeds normally. rsp_err is asserted only for size 11.

## Structure
- Package dmem_pkg: size encoding constants (SZ_BYTE, SZ_HALF, SZ_WORD), state enum, lane-mask function and misalignment function.
- One sub-module: dmem_load_align, the combinational lane select plus sign/zero extension for loads (inputs mem_rdata, size, addr[1:0], signed).

## Test plan
- Store word 0xDEADBEEF at addr 0x10, then load word at 0x10 → mem_we=1111, mem_addr=4; rsp_rdata=0xDEADBEEF 2 cycles after accept.
- Store byte 0x80 at 0x13, then signed load byte at 0x13 → mem_we=1000, mem_wdata=0x80808080; rsp_rdata=0xFFFFFF80; unsigned load → 0x00000080.
- Store half 0x8001 at 0x22, then signed and unsigned half loads at 0x22 → mem_we=1100; rsp_rdata 0xFFFF8001 and 0x00008001.
- Load word at 0x05 with DMEM_CTRL_MISALIGN_TRAP_EN → rsp_valid+rsp_err 1 cycle after accept, mem_we=0. Without the macro → reads word 1, rsp_err=0.
- Assert rst during ACCESS of a store to 0x08, then load 0x08 → old contents returned; outputs zero while in reset.
- Back-to-back req_valid held high for 3 requests → exactly 3 rsp_valid pulses, spaced 3 cycles apart, and no request lost or duplicated.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the byte-laned data memory controller.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << lo;
      SZ_HALF: lane_mask = lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_HALF: misaligned = lo[0];
      SZ_WORD: misaligned = |lo;
      default: misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: store_data = {4{wdata[7:0]}};
      SZ_HALF: store_data = {2{wdata[15:0]}};
      default: store_data = wdata;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/response and DMem bank bus of the load/store controller.
interface dmem_ctrl_if #(
  parameter int ADDR_W = 8
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-3:0] mem_addr;
  logic [3:0]        mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/dmem_load_align.sv
// Load formatting: picks the addressed byte/half out of the bank word and extends it to 32 bits.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  lo_i,
  input  logic        sgn_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select followed by sign or zero extension
  always_comb begin
    byte_s = rdata_i[{lo_i, 3'b000} +: 8];
    half_s = rdata_i[{lo_i[1], 4'b0000} +: 16];
    case (size_i)
      SZ_BYTE: data_o = {{24{sgn_i & byte_s[7]}}, byte_s};
      SZ_HALF: data_o = {{16{sgn_i & half_s[15]}}, half_s};
      SZ_WORD: data_o = rdata_i;
      default: data_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Load/store sequencer for four byte-lane DMem banks: IDLE -> ACCESS -> RESP, errors skip ACCESS.
// Define DMEM_CTRL_MISALIGN_TRAP_EN to reject misaligned half/word requests instead of ignoring low address bits.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  dmem_ctrl_if.slave bus
);

  state_e            state_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              sgn_q;
  logic [1:0]        lo_q;
  logic [ADDR_W-3:0] mem_addr_q;
  logic [3:0]        mem_we_q;
  logic [31:0]       mem_wdata_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;

  logic              err_d;
  logic [3:0]        mask_d;
  logic [31:0]       wdata_d;
  logic [31:0]       load_data;

`ifdef DMEM_CTRL_MISALIGN_TRAP_EN
  assign err_d = (bus.req_size == SZ_ILL) || misaligned(bus.req_size, bus.req_addr[1:0]);
`else
  assign err_d = (bus.req_size == SZ_ILL);
`endif

  // Store lane mask and lane-replicated data for the incoming request
  always_comb begin
    mask_d  = lane_mask(bus.req_size, bus.req_addr[1:0]);
    wdata_d = store_data(bus.req_size, bus.req_wdata);
  end

  // Request sequencing; every bus output except the load data is a register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      sgn_q       <= 1'b0;
      lo_q        <= 2'b00;
      mem_addr_q  <= '0;
      mem_we_q    <= 4'b0000;
      mem_wdata_q <= 32'h0000_0000;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          mem_we_q    <= 4'b0000;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          if (bus.req_valid) begin
            we_q   <= bus.req_we;
            size_q <= bus.req_size;
            sgn_q  <= bus.req_signed;
            lo_q   <= bus.req_addr[1:0];
            if (err_d) begin
              // Rejected requests never touch the banks and answer one cycle early
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else begin
              state_q     <= ST_ACCESS;
              mem_addr_q  <= bus.req_addr[ADDR_W-1:2];
              mem_we_q    <= bus.req_we ? mask_d : 4'b0000;
              mem_wdata_q <= wdata_d;
            end
          end
        end
        ST_ACCESS: begin
          state_q     <= ST_RESP;
          mem_we_q    <= 4'b0000;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
        end
        ST_RESP: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          mem_we_q    <= 4'b0000;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
        end
      endcase
    end
  end

  dmem_load_align u_load_align (
    .rdata_i (bus.mem_rdata),
    .size_i  (size_q),
    .lo_i    (lo_q),
    .sgn_i   (sgn_q),
    .data_o  (load_data)
  );

  assign bus.req_ready = (state_q == ST_IDLE) && !rst;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = (rsp_valid_q && !we_q && !rsp_err_q) ? load_data : 32'h0000_0000;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule
